// File: rtl/game_state_controller_pkg.sv
// Shared constants and types for the breakout game state controller.
// Grid geometry and wall/ceiling/paddle/bottom positions are also used by
// the renderer's block-coordinate comparators.
package game_state_controller_pkg;

  localparam int unsigned GRID_COLS = 80;
  localparam int unsigned GRID_ROWS = 60;

  localparam logic [5:0] CEILING_ROW    = 6'd7;
  localparam logic [6:0] LEFT_WALL_COL  = 7'd0;
  localparam logic [6:0] RIGHT_WALL_COL = 7'(GRID_COLS - 1);
  localparam logic [5:0] PADDLE_ROW_DEF = 6'd57;
  localparam logic [5:0] BOTTOM_ROW     = 6'(GRID_ROWS - 1);
  localparam logic [6:0] PADDLE_W       = 7'd8;
  localparam logic [6:0] PADDLE_HOME    = 7'd36;
  localparam logic [1:0] LIVES_START    = 2'd3;

  // Direction is a sign bit: 0 = +1, 1 = -1.
  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  typedef enum logic [1:0] {
    S_SERVE,
    S_PLAY,
    S_OVER
  } game_state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_PADDLE,
    SEQ_COLLIDE,
    SEQ_COMMIT
  } seq_state_t;

  // One-block move on a width-extended coordinate.
  function automatic logic [7:0] apply_dir(input logic [7:0] pos, input logic dir);
    return (dir == DIR_NEG) ? pos - 8'd1 : pos + 8'd1;
  endfunction

endpackage

// File: rtl/game_state_controller_ball_step_unit.sv
// ball_step_unit: combinational single ball step.
// Inputs : ball_x/ball_y current position, dx/dy sign-bit directions,
//          paddle_x (post-move leftmost paddle column).
// Outputs: new_x/new_y stepped position, new_dx/new_dy reflected directions,
//          miss when the stepped ball lands on the bottom row.
module ball_step_unit
  import game_state_controller_pkg::*;
#(
  parameter logic [5:0] CEILING_BLOCK    = CEILING_ROW,
  parameter logic [6:0] LEFT_WALL_BLOCK  = LEFT_WALL_COL,
  parameter logic [6:0] RIGHT_WALL_BLOCK = RIGHT_WALL_COL,
  parameter logic [5:0] PADDLE_ROW       = PADDLE_ROW_DEF,
  parameter logic [5:0] BOTTOM_BLOCK     = BOTTOM_ROW,
  parameter logic [6:0] PADDLE_WIDTH     = PADDLE_W
)(
  input  logic [6:0] ball_x,
  input  logic [5:0] ball_y,
  input  logic       dx,
  input  logic       dy,
  input  logic [6:0] paddle_x,
  output logic [6:0] new_x,
  output logic [5:0] new_y,
  output logic       new_dx,
  output logic       new_dy,
  output logic       miss
);

  logic [7:0] nx;
  logic [7:0] ny;
  logic [7:0] hit_x;
  logic [7:0] fin_y;
  logic [7:0] pad_lo;
  logic [7:0] pad_hi;

  always_comb begin
    nx     = apply_dir({1'b0, ball_x}, dx);
    new_dx = dx;
    if (nx == {1'b0, LEFT_WALL_BLOCK} || nx == {1'b0, RIGHT_WALL_BLOCK})
      new_dx = ~dx;

    // Paddle hit test uses the column the ball actually lands in, i.e.
    // after any wall reflection in this same step.
    hit_x  = apply_dir({1'b0, ball_x}, new_dx);
    pad_lo = {1'b0, paddle_x};
    pad_hi = pad_lo + {1'b0, PADDLE_WIDTH} - 8'd1;

    ny     = apply_dir({2'b00, ball_y}, dy);
    new_dy = dy;
    if (ny == {2'b00, CEILING_BLOCK})
      new_dy = ~dy;
    else if (dy == DIR_POS && ny == {2'b00, PADDLE_ROW} &&
             hit_x >= pad_lo && hit_x <= pad_hi)
      new_dy = ~dy;

    fin_y = apply_dir({2'b00, ball_y}, new_dy);
    new_x = hit_x[6:0];
    new_y = fin_y[5:0];
    miss  = (fin_y == {2'b00, BOTTOM_BLOCK});
  end

endmodule

// File: rtl/game_state_controller.sv
// game_state_controller: breakout paddle/ball/lives state, updated once per
// frame during vertical blanking and committed to the renderer atomically.
// Ports:
//   CLK, RESET_N         clock, asynchronous active-low reset
//   FRAME_TICK           start-of-vblank pulse (accepted only when idle)
//   BTN_LEFT/RIGHT/SERVE debounced buttons
//   PADDLE_X, BALL_X, BALL_Y, LIVES, GAME_OVER  committed game state
//   UPDATE_DONE          one-cycle pulse after outputs commit
module game_state_controller
  import game_state_controller_pkg::*;
#(
  parameter logic [5:0] CEILING_BLOCK    = CEILING_ROW,
  parameter logic [6:0] LEFT_WALL_BLOCK  = LEFT_WALL_COL,
  parameter logic [6:0] RIGHT_WALL_BLOCK = RIGHT_WALL_COL,
  parameter logic [5:0] PADDLE_ROW       = PADDLE_ROW_DEF,
  parameter logic [5:0] BOTTOM_BLOCK     = BOTTOM_ROW,
  parameter logic [6:0] PADDLE_WIDTH     = PADDLE_W,
  parameter logic [2:0] FRAMES_PER_STEP  = 3'd4
)(
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       FRAME_TICK,
  input  logic       BTN_LEFT,
  input  logic       BTN_RIGHT,
  input  logic       BTN_SERVE,
  output logic [6:0] PADDLE_X,
  output logic [6:0] BALL_X,
  output logic [5:0] BALL_Y,
  output logic [1:0] LIVES,
  output logic       GAME_OVER,
  output logic       UPDATE_DONE
);

  localparam logic [6:0] PADDLE_MIN = LEFT_WALL_BLOCK + 7'd1;
  localparam logic [6:0] PADDLE_MAX = RIGHT_WALL_BLOCK - PADDLE_WIDTH;
  localparam logic [6:0] SERVE_X    = PADDLE_HOME + (PADDLE_WIDTH >> 1);
  localparam logic [5:0] SERVE_Y    = PADDLE_ROW - 6'd1;

  seq_state_t  seq, seq_nx;
  game_state_t state, state_nx;
  logic [6:0]  px_w, px_nx, bx_w, bx_nx;
  logic [5:0]  by_w, by_nx;
  logic        dx_w, dx_nx, dy_w, dy_nx;
  logic [2:0]  cnt_w, cnt_nx;
  logic [1:0]  lives_w, lives_nx;
  logic        commit;

  logic [6:0]  step_x;
  logic [5:0]  step_y;
  logic        step_dx, step_dy, step_miss;

  ball_step_unit #(
    .CEILING_BLOCK   (CEILING_BLOCK),
    .LEFT_WALL_BLOCK (LEFT_WALL_BLOCK),
    .RIGHT_WALL_BLOCK(RIGHT_WALL_BLOCK),
    .PADDLE_ROW      (PADDLE_ROW),
    .BOTTOM_BLOCK    (BOTTOM_BLOCK),
    .PADDLE_WIDTH    (PADDLE_WIDTH)
  ) u_step (
    .ball_x  (bx_w),
    .ball_y  (by_w),
    .dx      (dx_w),
    .dy      (dy_w),
    .paddle_x(px_w),
    .new_x   (step_x),
    .new_y   (step_y),
    .new_dx  (step_dx),
    .new_dy  (step_dy),
    .miss    (step_miss)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      seq         <= SEQ_IDLE;
      state       <= S_SERVE;
      px_w        <= PADDLE_HOME;
      bx_w        <= SERVE_X;
      by_w        <= SERVE_Y;
      dx_w        <= DIR_POS;
      dy_w        <= DIR_NEG;
      cnt_w       <= '0;
      lives_w     <= LIVES_START;
      PADDLE_X    <= PADDLE_HOME;
      BALL_X      <= SERVE_X;
      BALL_Y      <= SERVE_Y;
      LIVES       <= LIVES_START;
      GAME_OVER   <= 1'b0;
      UPDATE_DONE <= 1'b0;
    end else begin
      seq         <= seq_nx;
      state       <= state_nx;
      px_w        <= px_nx;
      bx_w        <= bx_nx;
      by_w        <= by_nx;
      dx_w        <= dx_nx;
      dy_w        <= dy_nx;
      cnt_w       <= cnt_nx;
      lives_w     <= lives_nx;
      UPDATE_DONE <= commit;
      if (commit) begin
        PADDLE_X  <= px_w;
        BALL_X    <= bx_w;
        BALL_Y    <= by_w;
        LIVES     <= lives_w;
        GAME_OVER <= (state == S_OVER);
      end
    end
  end

  always_comb begin
    seq_nx   = seq;
    state_nx = state;
    px_nx    = px_w;
    bx_nx    = bx_w;
    by_nx    = by_w;
    dx_nx    = dx_w;
    dy_nx    = dy_w;
    cnt_nx   = cnt_w;
    lives_nx = lives_w;
    commit   = 1'b0;

    unique case (seq)
      SEQ_IDLE: if (FRAME_TICK) seq_nx = SEQ_PADDLE;

      SEQ_PADDLE: begin
        seq_nx = SEQ_COLLIDE;
        if (state != S_OVER) begin
          if (BTN_LEFT && !BTN_RIGHT && px_w > PADDLE_MIN)
            px_nx = px_w - 7'd1;
          else if (BTN_RIGHT && !BTN_LEFT && px_w < PADDLE_MAX)
            px_nx = px_w + 7'd1;
        end
      end

      SEQ_COLLIDE: begin
        seq_nx = SEQ_COMMIT;
        unique case (state)
          S_SERVE: begin
            bx_nx = px_w + (PADDLE_WIDTH >> 1);
            by_nx = SERVE_Y;
            if (BTN_SERVE) begin
              state_nx = S_PLAY;
              dx_nx    = DIR_POS;
              dy_nx    = DIR_NEG;
              cnt_nx   = '0;
            end
          end
          S_PLAY: begin
            if (cnt_w == FRAMES_PER_STEP - 3'd1) begin
              cnt_nx = '0;
              bx_nx  = step_x;
              by_nx  = step_y;
              dx_nx  = step_dx;
              dy_nx  = step_dy;
              if (step_miss) begin
                lives_nx = lives_w - 2'd1;
                state_nx = (lives_w == 2'd1) ? S_OVER : S_SERVE;
              end
            end else begin
              cnt_nx = cnt_w + 3'd1;
            end
          end
          S_OVER: begin
            if (BTN_SERVE) begin
              lives_nx = LIVES_START;
              px_nx    = PADDLE_HOME;
              state_nx = S_SERVE;
            end
          end
          default: state_nx = S_SERVE;
        endcase
      end

      SEQ_COMMIT: begin
        seq_nx = SEQ_IDLE;
        commit = 1'b1;
      end

      default: seq_nx = SEQ_IDLE;
    endcase
  end

endmodule
